// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and the constant used to fill LO on a divide by zero.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    // LO is filled with this bit on every position when the divisor is zero
    localparam logic DIV0_LO_BIT = 1'b1;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply and restoring
// shift-subtract divide, both advanced one bit per enabled step.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc,
    output logic [WIDTH-1:0]     quot,
    output logic [WIDTH-1:0]     rem
);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplr_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quot_r;
    logic [WIDTH-1:0]   dvsr_r;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH-1:0]   diff_s;
    logic               ge_s;

    // Trial subtraction: the shifted partial remainder carries one extra bit
    always_comb begin
        shifted_s = {rem_r, quot_r[WIDTH-1]};
        ge_s      = (shifted_s >= {1'b0, dvsr_r});
        diff_s    = shifted_s[WIDTH-1:0] - dvsr_r;
    end

    // Both datapaths are loaded together and stepped together; the FSM picks the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r   <= '0;
            mcand_r <= '0;
            mplr_r  <= '0;
            rem_r   <= '0;
            quot_r  <= '0;
            dvsr_r  <= '0;
        end else if (load) begin
            acc_r   <= '0;
            mcand_r <= {{WIDTH{1'b0}}, a};
            mplr_r  <= b;
            rem_r   <= '0;
            quot_r  <= a;
            dvsr_r  <= b;
        end else if (step) begin
            if (mplr_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end
            mcand_r <= mcand_r << 1;
            mplr_r  <= mplr_r >> 1;
            if (ge_s) begin
                rem_r  <= diff_s;
                quot_r <= {quot_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r  <= shifted_s[WIDTH-1:0];
                quot_r <= {quot_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign acc  = acc_r;
    assign quot = quot_r;
    assign rem  = rem_r;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers,
// MTHI/MTLO writes, MFHI/MFLO read port and pipeline stall generation.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             mt_we,
    input  logic             mt_hi,
    input  logic             mf_req,
    input  logic             mf_hi,
    output logic [WIDTH-1:0] rd,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               div_r;
    logic               dz_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   dvd_r;

    logic               sgn_s;
    logic               launch_s;
    logic               step_s;
    logic [WIDTH-1:0]   a_abs_s;
    logic [WIDTH-1:0]   b_abs_s;
    logic [2*WIDTH-1:0] core_acc_s;
    logic [WIDTH-1:0]   core_quot_s;
    logic [WIDTH-1:0]   core_rem_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // Operand magnitudes and core enables
    always_comb begin
        sgn_s    = op_is_signed(op);
        a_abs_s  = (sgn_s && srcA[WIDTH-1]) ? (-srcA) : srcA;
        b_abs_s  = (sgn_s && srcB[WIDTH-1]) ? (-srcB) : srcB;
        launch_s = start && (state_r == S_IDLE);
        step_s   = (state_r == S_RUN) && (cnt_r != '0);
    end

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (launch_s),
        .step  (step_s),
        .a     (a_abs_s),
        .b     (b_abs_s),
        .acc   (core_acc_s),
        .quot  (core_quot_s),
        .rem   (core_rem_s)
    );

    // Sign correction of the unsigned core result; divide by zero bypasses it
    always_comb begin
        prod_s   = neg_q_r ? (-core_acc_s) : core_acc_s;
        fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
        fix_lo_s = prod_s[WIDTH-1:0];
        if (!div_r) begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end else if (dz_r) begin
            fix_hi_s = dvd_r;
            fix_lo_s = {WIDTH{DIV0_LO_BIT}};
        end else begin
            fix_lo_s = neg_q_r ? (-core_quot_s) : core_quot_s;
            fix_hi_s = neg_r_r ? (-core_rem_s) : core_rem_s;
        end
    end

    // Control FSM, HI/LO commit and MT writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            div_r   <= 1'b0;
            dz_r    <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            dvd_r   <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= S_RUN;
                        busy_r  <= 1'b1;
                        cnt_r   <= CNT_W'(WIDTH);
                        div_r   <= op_is_div(op);
                        dz_r    <= op_is_div(op) && (srcB == '0);
                        neg_q_r <= sgn_s && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        neg_r_r <= sgn_s && srcA[WIDTH-1];
                        dvd_r   <= srcA;
                    end else if (mt_we) begin
                        if (mt_hi) begin
                            hi_r <= srcA;
                        end else begin
                            lo_r <= srcA;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt_r == '0) begin
                        state_r <= S_FIX;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rd    = mf_hi ? hi_r : lo_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign stall = busy_r && (mf_req || start || mt_we);

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: arithmetic reference model plus directed vectors.
module tb_mdu_hilo;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic         mt_we = 1'b0;
    logic         mt_hi = 1'b0;
    logic         mf_req = 1'b0;
    logic         mf_hi = 1'b0;
    logic [W-1:0] rd;
    logic         busy;
    logic         done;
    logic         stall;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int d0;

    int           m_left = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] m_nhi = '0;
    logic [W-1:0] m_nlo = '0;

    mdu_hilo #(.WIDTH(W), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .mt_we  (mt_we),
        .mt_hi  (mt_hi),
        .mf_req (mf_req),
        .mf_hi  (mf_hi),
        .rd     (rd),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // MIPS HI/LO result computed with plain 64-bit arithmetic
    function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULTU: p = {32'h0, a} * {32'h0, b};
            OP_MULT:  p = sa * sb;
            default: begin
                if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
                else if (o == OP_DIVU) p = {a % b, a / b};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Reference model: W+2 cycles from accepted start to commit, done in the last busy cycle
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left == 0) begin
            if (start) begin
                logic [W-1:0] th, tl;
                ref_op(op, srcA, srcB, th, tl);
                m_nhi  <= th;
                m_nlo  <= tl;
                m_left <= W + 2;
            end else if (mt_we) begin
                if (mt_hi) m_hi <= srcA;
                else m_lo <= srcA;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_nhi;
                m_lo <= m_nlo;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            chk("busy", busy, m_left != 0);
            chk("done", done, m_left == 1);
            chk("stall", stall, (m_left != 0) && (mf_req || start || mt_we));
            chk("rd", rd, mf_hi ? m_hi : m_lo);
            if (done) done_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic expect_hilo(input string nm, input logic [W-1:0] eh, input logic [W-1:0] el);
        mf_hi = 1'b1;
        #1 chk({nm, ".hi"}, rd, eh);
        mf_hi = 1'b0;
        #1 chk({nm, ".lo"}, rd, el);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc(2);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        expect_hilo("rst", 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // T1: exact latency and single done pulse
        d0 = done_cnt;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc(32);
        chk("t1.done_early", done, 1'b0);
        cyc(1);
        chk("t1.done", done, 1'b1);
        chk("t1.busy_fix", busy, 1'b1);
        expect_hilo("t1.old", 32'h0, 32'h0);
        cyc(1);
        chk("t1.busy_end", busy, 1'b0);
        chk("t1.done_end", done, 1'b0);
        chk("t1.pulses", done_cnt - d0, 32'd1);
        expect_hilo("t1", 32'hFFFF_FFFE, 32'h0000_0001);

        // T2: signed arithmetic, issued back-to-back
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_idle();
        expect_hilo("t2.mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        expect_hilo("t2.div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_idle();
        expect_hilo("t2.div2", 32'h0000_0001, 32'hFFFF_FFFD);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_idle();
        expect_hilo("t2.divu", 32'd2, 32'd14);

        // T3: divide by zero and the signed overflow case
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_idle();
        expect_hilo("t3.dz", 32'd100, 32'hFFFF_FFFF);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        expect_hilo("t3.ovf", 32'h0, 32'h8000_0000);
        issue(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        wait_idle();
        expect_hilo("t3.dzneg", 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // T4: MFLO held during an operation stalls until commit
        issue(OP_MULTU, 32'd6, 32'd7);
        cyc(2);
        mf_req = 1'b1;
        mf_hi = 1'b0;
        cyc(1);
        chk("t4.stall", stall, 1'b1);
        wait_idle();
        chk("t4.release", stall, 1'b0);
        chk("t4.rd", rd, 32'd42);
        mf_req = 1'b0;

        // T5: asynchronous reset mid-divide
        issue(OP_DIVU, 32'd1000, 32'd7);
        cyc(9);
        reset = 1'b1;
        #1 chk("t5.busy", busy, 1'b0);
        chk("t5.done", done, 1'b0);
        expect_hilo("t5.clr", 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        issue(OP_MULTU, 32'd2, 32'd3);
        wait_idle();
        expect_hilo("t5.mul", 32'h0, 32'd6);

        // T6: MT write and second start ignored while busy
        d0 = done_cnt;
        issue(OP_MULTU, 32'd5, 32'd5);
        cyc(3);
        mt_we = 1'b1; mt_hi = 1'b0; srcA = 32'h1234;
        cyc(1);
        mt_we = 1'b0;
        cyc(2);
        op = OP_DIVU; srcA = 32'd9; srcB = 32'd3; start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_idle();
        chk("t6.pulses", done_cnt - d0, 32'd1);
        expect_hilo("t6", 32'h0, 32'd25);
        cyc(1);
        chk("t6.still_idle", busy, 1'b0);
        mt_we = 1'b1; mt_hi = 1'b1; srcA = 32'hABCD;
        cyc(1);
        mt_we = 1'b0;
        mf_hi = 1'b1;
        #1 chk("t6.mthi", rd, 32'hABCD);
        mf_hi = 1'b0;
        #1 chk("t6.lo_kept", rd, 32'd25);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
